// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
//
// 32-bit integer arithmetic/logic unit for the execute stage. Out and Zero
// are purely combinational; Out_q is a registered copy of Out, one cycle
// later, for use by the next pipeline stage.
//
// Ports:
//   clk    - rising-edge clock, drives only the Out_q register
//   rst_n  - asynchronous active-low reset, clears Out_q
//   A      - operand A; the value being shifted for shift operations
//   B      - operand B; the shift amount for shift operations
//   ALUop  - operation select (see alu_op_e)
//   Out    - combinational result
//   Zero   - combinational, high when Out is all zeros
//   Out_q  - Out captured on every rising clk edge
// ---------------------------------------------------------------------------
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUop,
  output logic [WIDTH-1:0] Out,
  output logic             Zero,
  output logic [WIDTH-1:0] Out_q
);

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_AND    = 4'd2,
    OP_OR     = 4'd3,
    OP_XOR    = 4'd4,
    OP_SLT    = 4'd5,
    OP_SLTU   = 4'd6,
    OP_SLL    = 4'd7,
    OP_SRA    = 4'd8,
    OP_SRL    = 4'd9,
    OP_COPY_B = 4'd10
  } alu_op_e;

  // Width of the in-range shift amount. WIDTH is assumed to be a power of
  // two, so any set bit above this field means the shift is >= WIDTH.
  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0]   shamt;
  logic             big_shift;
  logic             slt_bit;
  logic             sltu_bit;
  logic [WIDTH-1:0] sll_res;
  logic [WIDTH-1:0] srl_res;
  logic [WIDTH-1:0] sra_res;
  logic [WIDTH-1:0] Out_d;

  // Shift and compare helpers. The whole of B is the shift amount, so an
  // out-of-range amount saturates to all-zeros (logical) or all-sign-bits
  // (arithmetic) instead of wrapping modulo WIDTH.
  always_comb begin
    shamt     = B[SHW-1:0];
    big_shift = |B[WIDTH-1:SHW];
    slt_bit   = $signed(A) < $signed(B);
    sltu_bit  = A < B;
    sll_res   = big_shift ? '0 : (A << shamt);
    srl_res   = big_shift ? '0 : (A >> shamt);
    sra_res   = big_shift ? {WIDTH{A[WIDTH-1]}}
                          : WIDTH'($signed(A) >>> shamt);
  end

  // Result select. SUB is deliberately B - A. Unused opcodes produce zero
  // so the output is always fully defined.
  always_comb begin
    Out_d = '0;
    case (ALUop)
      OP_ADD:    Out_d = A + B;
      OP_SUB:    Out_d = B - A;
      OP_AND:    Out_d = A & B;
      OP_OR:     Out_d = A | B;
      OP_XOR:    Out_d = A ^ B;
      OP_SLT:    Out_d = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_SLTU:   Out_d = {{(WIDTH-1){1'b0}}, sltu_bit};
      OP_SLL:    Out_d = sll_res;
      OP_SRA:    Out_d = sra_res;
      OP_SRL:    Out_d = srl_res;
      OP_COPY_B: Out_d = B;
      default:   Out_d = '0;
    endcase
  end

  assign Out  = Out_d;
  assign Zero = (Out_d == '0);

  // Pipeline copy of the result: no enable, captured every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Out_q <= '0;
    end else begin
      Out_q <= Out_d;
    end
  end

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu
//
// Self-checking bench for alu: directed vectors for each operation and the
// register/reset path, followed by random vectors for every opcode compared
// against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALUop;
  logic [31:0] Out;
  logic        Zero;
  logic [31:0] Out_q;

  int check_count = 0;
  int pass_count  = 0;

  alu #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .ALUop (ALUop),
    .Out   (Out),
    .Zero  (Zero),
    .Out_q (Out_q)
  );

  // Free-running 10-unit clock; rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model written as plain arithmetic on the operation table:
  // shifts are multiplications/divisions by powers of two, SRA is a floor
  // division of the signed value.
  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint ua;
    longint ub;
    longint sa;
    longint sb;
    longint p;
    longint q;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = 0;
    case (op)
      0:  q = ua + ub;
      1:  q = ub - ua;
      2:  q = longint'({32'd0, a & b});
      3:  q = longint'({32'd0, a | b});
      4:  q = longint'({32'd0, a ^ b});
      5:  q = (sa < sb) ? 1 : 0;
      6:  q = (ua < ub) ? 1 : 0;
      7:  begin
            if (ub >= 32) q = 0;
            else begin
              p = longint'(1) << ub;
              q = ua * p;
            end
          end
      8:  begin
            if (ub >= 32) q = (sa < 0) ? -1 : 0;
            else begin
              p = longint'(1) << ub;
              if (sa >= 0) q = sa / p;
              else         q = -((-sa + p - 1) / p);
            end
          end
      9:  begin
            if (ub >= 32) q = 0;
            else begin
              p = longint'(1) << ub;
              q = ua / p;
            end
          end
      10: q = ub;
      default: q = 0;
    endcase
    return q[31:0];
  endfunction

  // Random operand drawn from a mix of full-range values, sign-extended
  // 16-bit values, small shift-sized values and corner values.
  function automatic logic [31:0] rand_operand();
    logic [15:0] h;
    logic [31:0] corners [4];
    corners[0] = 32'h0000_0000;
    corners[1] = 32'hFFFF_FFFF;
    corners[2] = 32'h8000_0000;
    corners[3] = 32'h7FFF_FFFF;
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: begin
           h = 16'($urandom);
           return {{16{h[15]}}, h};
         end
      2: return 32'($urandom_range(0, 40));
      default: return corners[$urandom_range(0, 3)];
    endcase
  endfunction

  // Drive the operands and opcode, then let the combinational result settle.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] op);
    A     = a;
    B     = b;
    ALUop = op;
    #1;
  endtask

  // Compare Out and Zero against the expected result.
  task automatic checkOutput(input string tag, input logic [31:0] exp_out);
    logic exp_zero;
    exp_zero = (exp_out == 32'd0);
    check_count++;
    assert (Out === exp_out) pass_count++;
    else $error("[TB] FAIL %s Out: got %h expected %h (A=%h B=%h op=%0d)",
                tag, Out, exp_out, A, B, ALUop);
    check_count++;
    assert (Zero === exp_zero) pass_count++;
    else $error("[TB] FAIL %s Zero: got %b expected %b", tag, Zero, exp_zero);
  endtask

  // Compare the registered output against the expected value.
  task automatic checkReg(input string tag, input logic [31:0] exp_q);
    check_count++;
    assert (Out_q === exp_q) pass_count++;
    else $error("[TB] FAIL %s Out_q: got %h expected %h", tag, Out_q, exp_q);
  endtask

  // Directed steps, then the random regression, then the summary.
  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] exp_r;

    rst_n = 1'b0;
    A     = '0;
    B     = '0;
    ALUop = '0;
    $display("[TB] starting alu bench");

    // Reset held: Out_q stays zero across edges whatever the inputs.
    repeat (2) @(negedge clk);
    applyStimulus(32'hDEAD_BEEF, 32'h0000_1234, 4'd0);
    checkOutput("comb_in_reset", 32'hDEAD_BEEF + 32'h0000_1234);
    @(posedge clk);
    #1;
    checkReg("reset_hold", 32'd0);

    // Release and apply ADD 2+2: Out immediately, Out_q at the next edge.
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(32'd2, 32'd2, 4'd0);
    checkOutput("add_2_2", 32'd4);
    checkReg("pre_first_edge", 32'd0);
    @(posedge clk);
    #1;
    checkReg("first_capture", 32'd4);

    // Mid-cycle change reaches Out at once but not Out_q.
    applyStimulus(32'd5, 32'd5, 4'd0);
    checkOutput("mid_cycle_out", 32'd10);
    checkReg("mid_cycle_hold", 32'd4);

    // Asynchronous reset between edges clears Out_q without a clock.
    rst_n = 1'b0;
    #1;
    checkReg("async_reset", 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Arithmetic.
    @(negedge clk); applyStimulus(32'd5, 32'd3, 4'd0);  checkOutput("add_5_3", 32'd8);
    @(negedge clk); applyStimulus(32'd5, 32'd3, 4'd1);  checkOutput("sub_b_minus_a", 32'hFFFF_FFFE);
    @(negedge clk); applyStimulus(32'hFFFF_FFFF, 32'd1, 4'd0); checkOutput("add_wrap", 32'd0);

    // Logic, copy and an undefined opcode.
    @(negedge clk); applyStimulus(32'h0000_F0F0, 32'h0000_FF00, 4'd2);  checkOutput("and", 32'h0000_F000);
    @(negedge clk); applyStimulus(32'h0000_F0F0, 32'h0000_FF00, 4'd3);  checkOutput("or", 32'h0000_FFF0);
    @(negedge clk); applyStimulus(32'h0000_F0F0, 32'h0000_FF00, 4'd4);  checkOutput("xor", 32'h0000_0FF0);
    @(negedge clk); applyStimulus(32'h0000_F0F0, 32'h0000_FF00, 4'd10); checkOutput("copy_b", 32'h0000_FF00);
    @(negedge clk); applyStimulus(32'h0000_F0F0, 32'h0000_FF00, 4'd15); checkOutput("op15", 32'd0);

    // Compares, including equal operands.
    @(negedge clk); applyStimulus(32'hFFFF_FFFF, 32'd1, 4'd5); checkOutput("slt_neg", 32'd1);
    @(negedge clk); applyStimulus(32'hFFFF_FFFF, 32'd1, 4'd6); checkOutput("sltu_big", 32'd0);
    @(negedge clk); applyStimulus(32'd7, 32'd7, 4'd5); checkOutput("slt_eq", 32'd0);
    @(negedge clk); applyStimulus(32'd7, 32'd7, 4'd6); checkOutput("sltu_eq", 32'd0);

    // Shifts, in range and saturated.
    @(negedge clk); applyStimulus(32'h8000_0010, 32'd4, 4'd7);  checkOutput("sll_4", 32'h0000_0100);
    @(negedge clk); applyStimulus(32'h8000_0010, 32'd4, 4'd8);  checkOutput("sra_4", 32'hF800_0001);
    @(negedge clk); applyStimulus(32'h8000_0010, 32'd4, 4'd9);  checkOutput("srl_4", 32'h0800_0001);
    @(negedge clk); applyStimulus(32'h8000_0010, 32'd40, 4'd7); checkOutput("sll_40", 32'd0);
    @(negedge clk); applyStimulus(32'h8000_0010, 32'd40, 4'd8); checkOutput("sra_40", 32'hFFFF_FFFF);
    @(negedge clk); applyStimulus(32'h8000_0010, 32'd40, 4'd9); checkOutput("srl_40", 32'd0);

    // Random regression: 100 vectors per opcode; also checks Out_q one edge later.
    for (int op = 0; op < 16; op++) begin
      for (int n = 0; n < 100; n++) begin
        ra = rand_operand();
        rb = rand_operand();
        exp_r = ref_alu(op, ra, rb);
        @(negedge clk);
        applyStimulus(ra, rb, 4'(op));
        checkOutput("random", exp_r);
        @(posedge clk);
        #1;
        checkReg("random_q", exp_r);
      end
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
